adiciona_chave_rodada: RTL
==========================

# adiciona_chave_rodada

AES-128 AddRoundKey stage with an on-the-fly key schedule, sitting directly upstream of the byte-substitution stage in the encryption round datapath. It loads the cipher key and plaintext, then emits round 0 as `bloco ^ chave`. For each state returned by the round datapath (after ShiftRows/MixColumns), it derives the next round key and emits `estado ^ chave_rodada`, for rounds 1..10. Output is registered; one round key is generated per accepted input.

## Interface
- No parameters; fixed AES-128 (10 rounds, 128-bit key and block).
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `carrega` input 1: load pulse; samples `chave` and `bloco`.
- `chave` input 128: cipher key; byte 0 = `[127:120]`, word w0 = `[127:96]`.
- `bloco` input 128: plaintext, same byte order.
- `entrada_valida` input 1: `estado` holds the next round's pre-key state.
- `estado` input 128: state from the round datapath.
- `saida` output 128: registered AddRoundKey result, fed to byte substitution.
- `saida_valida` output 1: one-cycle pulse; `saida` is new.
- `rodada` output 4: round index of the current `saida` (0..10).
- `ultima` output 1: high with `saida_valida` when `rodada` = 10.
- `ocupado` output 1: high while waiting for rounds 1..10.

## Operation
- States: OCIOSO, ESPERA.
- OCIOSO:
  - `carrega`: `saida` <= `bloco ^ chave`; key register <= `chave`; `rodada` <= 0; pulse `saida_valida`; go to ESPERA.
  - `entrada_valida` is ignored.
- ESPERA, on `entrada_valida`:
  - Compute next key `k'` from key register `k` (words w0..w3):
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}
    - w1' = w1 ^ w0'
    - w2' = w2 ^ w1'
    - w3' = w3 ^ w2'
  - Key register <= `k'`; `saida` <= `estado ^ k'`; `rodada` <= `rodada`+1; pulse `saida_valida`.
  - If the new `rodada` = 10: pulse `ultima` and go to OCIOSO.
- Rcon for new rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- RotWord rotates bytes left by one: {b1,b2,b3,b0}.
- SubWord applies the standard AES S-box per byte.
- `carrega` in ESPERA restarts at round 0, discarding the schedule.
- `carrega` and `entrada_valida` together: `carrega` wins.
- `ocupado` = (state == ESPERA).

## Timing
- Reset values: `saida` = 0, `saida_valida` = 0, `ultima` = 0, `rodada` = 0, `ocupado` = 0, key register = 0, state = OCIOSO.
- Latency: 1 cycle from an accepted `carrega`/`entrada_valida` edge to `saida_valida`.
- Throughput: one round per cycle; back-to-back `entrada_valida` is legal.
- `saida`, `rodada` and `ultima` hold their values until the next accepted event. `ultima` and `saida_valida` are single-cycle pulses.
- Reset asserted mid-encryption: all outputs return to reset values immediately, with no further pulses.
- The key schedule is combinational from the key register: one S-box word plus an XOR chain in one cycle.

## Structure
- Shared package/header holds:
  - Rcon constants.
  - Round count (10).
  - State encodings OCIOSO/ESPERA.
- Sub-module `substitui_palavra`: 32-bit SubWord made of four byte S-box lookups. It uses the same S-box content as the block substitution stage; the table is kept in a single shared include.
- Top level contains the FSM, round counter, key register and output registers.

## Test plan
- Load key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> next cycle `saida` = 193de3bea0f4e22b9ac68d2ae9f84808, `rodada` = 0, `ocupado` = 1.
- Same key, then 10 back-to-back `entrada_valida` with `estado` = 0:
  - round 1 `saida` = a0fafe1788542cb123a339392a6c7605;
  - round 10 `saida` = d014f9a8c9ee2589e13f0cc8b6630ca6 with `ultima` = 1; `ocupado` = 0 afterwards.
- Key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> round 0 `saida` = 00102030405060708090a0b0c0d0e0f0; round 1 with `estado` = 0 gives d6aa74fdd2af72fadaa678f1d6ab76fe.
- Apply `carrega` and `entrada_valida` together at round 4 -> round 0 output for the new key/block; `rodada` = 0.
- Assert `reset` after round 5 -> outputs zero at once; later `entrada_valida` produces no pulse until the next `carrega`.
- `entrada_valida` in OCIOSO after reset -> no `saida_valida`; `saida` stays 0.

Source files
------------

// File: rtl/adiciona_chave_rodada_pkg.sv
// Shared AES constants: round count, Rcon, FSM encodings and the S-box table
// used by both the key schedule and the block substitution stage.
package adiciona_chave_rodada_pkg;

  localparam logic [3:0] N_RODADAS = 4'd10;

  typedef enum logic {
    OCIOSO = 1'b0,
    ESPERA = 1'b1
  } estado_fsm_t;

  // Row-major S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[(255 - int'(b))*8 +: 8];
  endfunction

  // Round constant for the round being produced (1..10)
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/adiciona_chave_rodada_substitui_palavra.sv
// SubWord: four independent S-box lookups on a 32-bit key-schedule word.
module substitui_palavra
  import adiciona_chave_rodada_pkg::*;
(
  input  logic [31:0] palavra,
  output logic [31:0] substituida
);

  assign substituida = {sbox(palavra[31:24]), sbox(palavra[23:16]),
                        sbox(palavra[15:8]),  sbox(palavra[7:0])};

endmodule

// File: rtl/adiciona_chave_rodada.sv
// AES-128 AddRoundKey with on-the-fly key expansion; emits round 0 on load and
// rounds 1..10 as each post-MixColumns state arrives.
module adiciona_chave_rodada
  import adiciona_chave_rodada_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [127:0] chave,
  input  logic [127:0] bloco,
  input  logic         entrada_valida,
  input  logic [127:0] estado,
  output logic [127:0] saida,
  output logic         saida_valida,
  output logic [3:0]   rodada,
  output logic         ultima,
  output logic         ocupado
);

  estado_fsm_t  fsm;
  logic [127:0] chave_p1;
  logic [127:0] chave_prox;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  n0, n1, n2, n3;
  logic [31:0]  sub_rot;
  logic [3:0]   rodada_prox;

  assign {w0, w1, w2, w3} = chave_p1;
  assign rodada_prox      = rodada + 4'd1;

  substitui_palavra u_subword (
    .palavra     ({w3[23:0], w3[31:24]}),
    .substituida (sub_rot)
  );

  // Next round key: one S-box word followed by the w0..w3 XOR chain
  assign n0 = w0 ^ sub_rot ^ {rcon(rodada_prox), 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign chave_prox = {n0, n1, n2, n3};

  assign ocupado = (fsm == ESPERA);

  // Registered outputs, key register and FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm          <= OCIOSO;
      chave_p1     <= '0;
      saida        <= '0;
      saida_valida <= 1'b0;
      ultima       <= 1'b0;
      rodada       <= '0;
    end else begin
      saida_valida <= 1'b0;
      ultima       <= 1'b0;
      if (carrega) begin
        chave_p1     <= chave;
        saida        <= bloco ^ chave;
        rodada       <= '0;
        saida_valida <= 1'b1;
        fsm          <= ESPERA;
      end else if (fsm == ESPERA && entrada_valida) begin
        chave_p1     <= chave_prox;
        saida        <= estado ^ chave_prox;
        rodada       <= rodada_prox;
        saida_valida <= 1'b1;
        if (rodada_prox == N_RODADAS) begin
          ultima <= 1'b1;
          fsm    <= OCIOSO;
        end
      end
    end
  end

endmodule
